// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: widths, register-zero index,
// control bundle layout and forwarding source encoding.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Field offsets inside the opaque decoded control bundle
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_SRC_A_BIT  = 4;
    localparam int CTRL_SRC_B_BIT  = 5;
    localparam int CTRL_BRANCH_BIT = 6;
    localparam int CTRL_STORE_BIT  = 7;

    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_RF   = 2'd3
    } fwd_sel_e;

    // Priority: x0, then the younger EX result, then MEM, then the regfile
    function automatic fwd_sel_e fwd_select(input logic is_zero,
                                            input logic ex_hit,
                                            input logic mem_hit);
        if (is_zero)      return FWD_ZERO;
        else if (ex_hit)  return FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register: zero / EX / MEM / regfile.
module fwd_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      src_addr,
    input  logic            ex_fwd_en,
    input  logic [4:0]      ex_rd_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_reg_we,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] data
);
    import core_pkg::*;

    logic     is_zero;
    logic     ex_hit;
    logic     mem_hit;
    fwd_sel_e sel;

    assign is_zero = (src_addr == REG_ZERO);
    assign ex_hit  = ex_fwd_en && (ex_rd_addr == src_addr);
    assign mem_hit = mem_reg_we && (mem_rd_addr == src_addr);
    assign sel     = fwd_select(is_zero, ex_hit, mem_hit);

    // Select the freshest value of the source register
    always_comb begin
        data = rf_data;
        case (sel)
            FWD_ZERO: data = '0;
            FWD_EX:   data = ex_data;
            FWD_MEM:  data = mem_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with operand forwarding, load-use hazard
// detection, branch flush and EX back-pressure.
module id_ex_operand_stage #(
    parameter int CTRL_W = core_pkg::CTRL_W,
    parameter int XLEN   = core_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic [4:0]        mem_rd_addr,
    input  logic              mem_reg_we,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [31:0]       stall_cnt
);
    import core_pkg::*;

    logic            ex_fwd_en;
    logic            load_use;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // A load's EX-stage value is an address, not the data: never forward it
    assign ex_fwd_en = ex_valid && ex_reg_we && !ex_mem_rd;

    assign load_use = id_valid && ex_valid && ex_mem_rd && ex_reg_we
                      && (ex_rd_addr != REG_ZERO)
                      && ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

    // A flushed ID instruction is killed rather than held
    assign id_stall = (load_use || ex_hold) && !flush;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .src_addr    (id_rs1_addr),
        .ex_fwd_en   (ex_fwd_en),
        .ex_rd_addr  (ex_rd_addr),
        .ex_data     (ex_fwd_data),
        .mem_reg_we  (mem_reg_we),
        .mem_rd_addr (mem_rd_addr),
        .mem_data    (mem_fwd_data),
        .rf_data     (id_rs1_data),
        .data        (op_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .src_addr    (id_rs2_addr),
        .ex_fwd_en   (ex_fwd_en),
        .ex_rd_addr  (ex_rd_addr),
        .ex_data     (ex_fwd_data),
        .mem_reg_we  (mem_reg_we),
        .mem_rd_addr (mem_rd_addr),
        .mem_data    (mem_fwd_data),
        .rf_data     (id_rs2_data),
        .data        (op_b)
    );

    // Pipeline register update: reset > hold > flush > load-use bubble > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            ex_rd_addr <= '0;
            ex_reg_we  <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_op_a    <= '0;
            ex_op_b    <= '0;
            stall_cnt  <= '0;
        end else if (ex_hold) begin
            ex_valid <= ex_valid;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_reg_we <= 1'b0;
            ex_mem_rd <= 1'b0;
        end else if (load_use) begin
            ex_valid  <= 1'b0;
            ex_reg_we <= 1'b0;
            ex_mem_rd <= 1'b0;
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
            ex_rd_addr <= id_rd_addr;
            ex_reg_we  <= id_reg_we && id_valid;
            ex_mem_rd  <= id_mem_rd;
            ex_op_a    <= op_a;
            ex_op_b    <= op_b;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: expected EX-stage values are
// queued when ID stimulus is driven and compared after the capturing edge.
module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam int S_VALID = 0, S_PC = 1, S_IMM = 2, S_CTRL = 3, S_RD = 4,
                   S_WE = 5, S_MRD = 6, S_OPA = 7, S_OPB = 8, S_CNT = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic              id_reg_we, id_mem_rd;
    logic [XLEN-1:0]   ex_fwd_data, mem_fwd_data;
    logic [4:0]        mem_rd_addr;
    logic              mem_reg_we, flush, ex_hold;
    logic              id_stall, ex_valid, ex_reg_we, ex_mem_rd;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_op_a, ex_op_b;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rd_addr;
    logic [31:0]       stall_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd_addr(id_rd_addr),
        .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .ex_fwd_data(ex_fwd_data),
        .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_rd_addr(ex_rd_addr),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_VALID: return {31'd0, ex_valid};
            S_PC:    return ex_pc;
            S_IMM:   return ex_imm;
            S_CTRL:  return {24'd0, ex_ctrl};
            S_RD:    return {27'd0, ex_rd_addr};
            S_WE:    return {31'd0, ex_reg_we};
            S_MRD:   return {31'd0, ex_mem_rd};
            S_OPA:   return ex_op_a;
            S_OPB:   return ex_op_b;
            default: return stall_cnt;
        endcase
    endfunction

    task automatic expect_ex(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Clock once, then drain the scoreboard against the registered outputs
    task automatic tick();
        sb_entry_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic we, input logic mrd);
        id_valid    = v;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_rd_addr  = rd;
        id_reg_we   = we;
        id_mem_rd   = mrd;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, id_stall}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        id_pc = 32'h40; id_imm = 32'h7; id_ctrl = 8'h5A;
        id_rs1_data = 32'hAAAA; id_rs2_data = 32'hBBBB;
        ex_fwd_data = '0; mem_fwd_data = '0; mem_rd_addr = '0;
        mem_reg_we = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        id_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);

        // Reset with a live ID instruction present
        tick();
        check_stall("rst_stall", 1'b0);
        expect_ex("rst_valid", S_VALID, 32'd0);
        expect_ex("rst_op_a", S_OPA, 32'd0);
        expect_ex("rst_cnt", S_CNT, 32'd0);
        tick();
        rst = 1'b0;

        // EX forwarding: put add x5 in EX, then read x5 in ID
        id_instr(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        id_pc = 32'h100;
        expect_ex("adv_valid", S_VALID, 32'd1);
        expect_ex("adv_rd", S_RD, 32'd5);
        expect_ex("adv_pc", S_PC, 32'h100);
        tick();
        id_instr(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        ex_fwd_data = 32'h11; id_rs1_data = 32'hDEAD;
        expect_ex("exfwd_op_a", S_OPA, 32'h11);
        expect_ex("exfwd_op_b_x0", S_OPB, 32'd0);
        tick();

        // EX beats MEM for the same destination; invalid EX falls back to MEM
        id_instr(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        id_instr(1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0);
        ex_fwd_data = 32'hA; mem_rd_addr = 5'd7; mem_reg_we = 1'b1;
        mem_fwd_data = 32'hB; id_rs2_data = 32'hC;
        expect_ex("prio_ex_op_b", S_OPB, 32'hA);
        expect_ex("bubble_we", S_WE, 32'd0);
        tick();
        expect_ex("prio_mem_op_b", S_OPB, 32'hB);
        tick();

        // Load-use: lw x3 in EX, add x4,x3,x0 in ID
        mem_reg_we = 1'b0;
        id_instr(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        expect_ex("lw_mrd", S_MRD, 32'd1);
        tick();
        id_instr(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        id_rs1_data = 32'h77;
        check_stall("lu_stall", 1'b1);
        expect_ex("lu_bubble", S_VALID, 32'd0);
        expect_ex("lu_cnt", S_CNT, 32'd1);
        tick();
        mem_rd_addr = 5'd3; mem_reg_we = 1'b1; mem_fwd_data = 32'h55;
        check_stall("lu_one_cycle", 1'b0);
        expect_ex("lu_memfwd_op_a", S_OPA, 32'h55);
        expect_ex("lu_adv_valid", S_VALID, 32'd1);
        expect_ex("lu_adv_rd", S_RD, 32'd4);
        tick();

        // x0 is never forwarded, even from an EX instruction targeting x0
        mem_reg_we = 1'b0;
        id_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        id_instr(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        ex_fwd_data = 32'h99; id_rs1_data = 32'h123;
        expect_ex("x0_op_a", S_OPA, 32'd0);
        tick();

        // Flush overrides a load-use hazard and is not counted
        id_instr(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        id_instr(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        check_stall("flush_lu_stall", 1'b0);
        expect_ex("flush_valid", S_VALID, 32'd0);
        expect_ex("flush_cnt", S_CNT, 32'd1);
        tick();
        flush = 1'b0;

        // Hold: a valid instruction stays frozen for three cycles
        id_instr(1'b1, 5'd10, 5'd11, 5'd9, 1'b1, 1'b0);
        id_pc = 32'h100; id_imm = 32'h5; id_ctrl = 8'h3C;
        id_rs1_data = 32'h1234; id_rs2_data = 32'h5678;
        expect_ex("pre_hold_op_a", S_OPA, 32'h1234);
        expect_ex("pre_hold_ctrl", S_CTRL, 32'h3C);
        tick();
        ex_hold = 1'b1;
        id_pc = 32'h200; id_imm = 32'h9; id_ctrl = 8'hFF;
        id_rs1_data = 32'h5555; id_rs2_data = 32'h6666;
        id_instr(1'b1, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            check_stall((i == 2) ? "hold_flush_stall" : "hold_stall", (i != 2));
            expect_ex("hold_valid", S_VALID, 32'd1);
            expect_ex("hold_pc", S_PC, 32'h100);
            expect_ex("hold_imm", S_IMM, 32'h5);
            expect_ex("hold_op_a", S_OPA, 32'h1234);
            expect_ex("hold_op_b", S_OPB, 32'h5678);
            expect_ex("hold_rd", S_RD, 32'd9);
            tick();
        end
        ex_hold = 1'b0; flush = 1'b0;

        // Counter wrap: preload all-ones, then a load-use via rs2
        id_instr(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        id_instr(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0);
        chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        check_stall("wrap_lu_stall", 1'b1);
        expect_ex("wrap_cnt", S_CNT, 32'd0);
        expect_ex("wrap_bubble", S_VALID, 32'd0);
        tick();

        if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
